shiftreg_serializer: RTL
========================

# shiftreg_serializer

Parametrised, handshaked successor to our parallel-load shift register: accepts an N-bit word over a valid/ready load port, shifts it out on `sout` MSB- or LSB-first while simultaneously shifting `sin` in, and presents the N received bits on a parallel output once the frame completes. The frame runs under a bit counter and a small state machine, and shifting is gated by an external `shift_en` tick, so the block sits between a word-level producer/consumer and any bit-rate serial link (SPI-like or loopback test paths).

## Interface
- `N`, 9: word width in bits, N >= 2; counter width is derived internally as ceil(log2(N)).
- `IDLE_LEVEL`, 1'b0: value driven on `sout` while idle.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising `clk`, low forces reset state.
- `ld_valid` in 1: load request; `d` and `lsb_first` valid with it.
- `ld_ready` out 1: block can accept a load (high only in IDLE).
- `d` in N: parallel word to transmit.
- `lsb_first` in 1: 1 = LSB first, 0 = MSB first; sampled only at load acceptance.
- `shift_en` in 1: bit tick; one shift per cycle it is high while in SHIFT.
- `sin` in 1: serial input, sampled on each shift.
- `sout` out 1: serial output (registered state, combinational select).
- `q` out N: last received word, held until the next frame completes.
- `busy` out 1: high in SHIFT and DONE.
- `done` out 1: single-cycle pulse at frame completion; `q` is updated in the same cycle.

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE: `ld_ready`=1, `busy`=0, `sout`=IDLE_LEVEL. On an edge with `ld_valid`=1: the shift register takes `d`, the direction flag takes `lsb_first`, the counter goes to 0, and the state goes to SHIFT.
- SHIFT: `sout` = shreg[N-1] (MSB-first) or shreg[0] (LSB-first). On an edge with `shift_en`=1:
  - MSB-first: shreg <= {shreg[N-2:0], sin}.
  - LSB-first: shreg <= {sin, shreg[N-1:1]}.
  - The counter increments.
  - If the counter was N-1, go to DONE; this is the Nth shift, and the counter then wraps to 0.
- On an edge with `shift_en`=0 in SHIFT, nothing changes; `sout` holds the current bit.
- DONE (one cycle): `done`=1, `q` <= shreg (the fully received word), `sout`=IDLE_LEVEL, then IDLE unconditionally.
- `ld_valid` outside IDLE is ignored; there is no queuing.
- `shift_en` outside SHIFT is ignored.
- `lsb_first` and `d` changes mid-frame have no effect.
- Reset (low at an edge, in any state, including mid-frame):
  - State goes to IDLE; shreg, counter, direction flag and `q` are cleared to 0.
  - `done`=0, `busy`=0, `ld_ready`=1, `sout`=IDLE_LEVEL.
  - The frame in flight is abandoned and `done` is not pulsed.

## Timing
- Load is accepted at edge E0 (IDLE, `ld_valid`=1).
- The first bit is on `sout` in the cycle after E0.
- Each subsequent bit appears in the cycle after each `shift_en` edge.
- With `shift_en` tied high:
  - Bit k (k=0..N-1) is on `sout` during cycle E0+1+k.
  - DONE occupies cycle E0+N+1, so `done` and the new `q` are visible then.
  - `ld_ready`=1 again at cycle E0+N+2.
  - Minimum load-to-load period is N+2 cycles.
- The `sin` bit sampled at the Nth shift edge lands in q[0] (MSB-first) or q[N-1] (LSB-first).
- `done` is exactly one cycle wide and never back-to-back.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release -> `ld_ready`=1, `busy`=0, `done`=0, `q`=0, `sout`=0.
- MSB-first send, N=9, `shift_en`=1: load `d`=9'h1A5, `lsb_first`=0, `sin`=1 -> `sout` sequence 1,1,0,1,0,0,1,0,1; `done` pulses at E0+10; `q`=9'h1FF.
- LSB-first loopback (`sin`=`sout`): load 9'h1A5, `lsb_first`=1 -> `sout` sequence 1,0,1,0,0,1,0,1,1; `q`=9'h1A5 at `done`.
- Gapped ticks: `shift_en` high every third cycle, load 9'h0F0 MSB-first, `sin`=0 -> each bit held 3 cycles; `done` follows the 9th tick by one cycle; `q`=0. A `ld_valid` pulse with 9'h1FF mid-frame is ignored and `ld_ready` stays 0.
- Reset mid-frame: load 9'h155, pull `reset` low after 4 shifts -> next cycle IDLE, `q`=0, no `done` pulse. A fresh load of 9'h003 then completes normally.
- Direction latch: load with `lsb_first`=1, toggle `lsb_first` every cycle during the frame -> output order stays LSB-first throughout.

Source files
------------

// File: rtl/shiftreg_serializer.sv
// Handshaked N-bit serializer/deserializer: loads a word, shifts it out on sout
// while capturing sin, and presents the received word on q when the frame ends.
module shiftreg_serializer #(
  parameter int   N          = 9,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [N-1:0] d,
  input  logic         lsb_first,
  input  logic         shift_en,
  input  logic         sin,
  output logic         sout,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  shreg;
  logic [N-1:0]  shreg_next;
  logic [CW-1:0] cnt;
  logic          dir;

  always_comb begin
    shreg_next = dir ? {sin, shreg[N-1:1]} : {shreg[N-2:0], sin};
  end

  assign sout = (state == SHIFT) ? (dir ? shreg[0] : shreg[N-1]) : IDLE_LEVEL;

  // q is written on the final shift edge so it is already valid while done is high
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      dir      <= 1'b0;
      q        <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ld_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_valid) begin
            shreg    <= d;
            dir      <= lsb_first;
            cnt      <= '0;
            state    <= SHIFT;
            busy     <= 1'b1;
            ld_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            shreg <= shreg_next;
            if (cnt == CW'(N - 1)) begin
              cnt   <= '0;
              q     <= shreg_next;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ld_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ld_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
